// File: rtl/fxp_div_if.sv
// Request/response bundle for the fixed-point divider: operands with start, quotient with status.
interface fxp_div_if #(
    parameter int WIDTH = 25
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] val;
    logic             ovf;
    logic             dbz;

    modport master (
        output start, a, b,
        input  busy, done, val, ovf, dbz
    );

    modport slave (
        input  start, a, b,
        output busy, done, val, ovf, dbz
    );
endinterface

// File: rtl/fxp_div.sv
// Signed Q(WIDTH-FBITS).FBITS divider: restoring radix-2, one quotient bit per clock, RNE rounding, saturating.
// Latency: N+2 cycles start-to-done (N=WIDTH+FBITS), 1 cycle for a zero divisor.
// Backpressure: none queued; start is only sampled while idle, requests during busy/done are dropped.
module fxp_div #(
    parameter int WIDTH = 25,
    parameter int FBITS = 20
) (
    input  logic      clk,
    input  logic      rst_n,
    fxp_div_if.slave  bus
);
    localparam int N  = WIDTH + FBITS;
    localparam int CW = $clog2(N);

    localparam logic [N:0]       QMAX_POS = {{(N-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [N:0]       QMAX_NEG = {{(N-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] VMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, ROUND, FIN} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] absb_q, absb_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             rem_ge;
    logic [WIDTH+1:0] rem2, b2;
    logic             round_up;
    logic [N:0]       qr;
    logic [WIDTH-1:0] qr_neg;

    // Most negative operand maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
    assign a_abs = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_abs = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

    assign rem_sh  = {rem_q[WIDTH-1:0], dvd_q[N-1]};
    assign rem_ge  = rem_sh >= {1'b0, absb_q};
    assign rem_sub = rem_sh - {1'b0, absb_q};

    // Half-LSB decision from the final remainder; ties go to the even quotient.
    assign rem2     = {rem_q, 1'b0};
    assign b2       = {2'b00, absb_q};
    assign round_up = (rem2 > b2) || ((rem2 == b2) && quo_q[0]);
    assign qr       = {1'b0, quo_q} + {{N{1'b0}}, round_up};
    assign qr_neg   = ~qr[WIDTH-1:0] + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        absb_d  = absb_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        val_d   = bus.a[WIDTH-1] ? VMIN : VMAX;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = FIN;
                    end else begin
                        sign_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        absb_d  = b_abs;
                        dvd_d   = {a_abs, {FBITS{1'b0}}};
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(N - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_ge ? rem_sub : rem_sh;
                dvd_d = {dvd_q[N-2:0], 1'b0};
                quo_d = {quo_q[N-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ROUND: begin
                if (!sign_q && (qr > QMAX_POS)) begin
                    val_d = VMAX;
                    ovf_d = 1'b1;
                end else if (sign_q && (qr > QMAX_NEG)) begin
                    val_d = VMIN;
                    ovf_d = 1'b1;
                end else begin
                    val_d = sign_q ? qr_neg : qr[WIDTH-1:0];
                    ovf_d = 1'b0;
                end
                dbz_d   = 1'b0;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            absb_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            absb_q  <= absb_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == ROUND);
    assign bus.done = (state_q == FIN);
    assign bus.val  = val_q;
    assign bus.ovf  = ovf_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_fxp_div.sv
// Directed-vector bench for fxp_div at default Q5.20 with hand-computed quotients.
module tb_fxp_div;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    fxp_div_if #(.WIDTH(25)) dif ();

    fxp_div #(.WIDTH(25), .FBITS(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one division, count cycles to done, check result and the cycle after.
    task automatic run_div(input string tag, input logic [24:0] a, input logic [24:0] b,
                           input logic [24:0] ev, input logic eo, input logic ed,
                           input int elat, input int inj);
        int cyc;
        @(negedge clk);
        dif.a     = a;
        dif.b     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.a     = ~a;
        dif.b     = ~b;
        cyc       = 1;
        if (elat > 1) chk({tag, ":busy"}, 32'(dif.busy), 32'd1);
        while (!dif.done && cyc < 200) begin
            if (inj != 0 && cyc == inj) begin
                dif.start = 1'b1;
                dif.a     = 25'h0F00000;
                dif.b     = 25'h0040000;
            end else begin
                dif.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dif.start = 1'b0;
        chk({tag, ":lat"}, 32'(cyc), 32'(elat));
        chk({tag, ":val"}, 32'(dif.val), 32'(ev));
        chk({tag, ":ovf"}, 32'(dif.ovf), 32'(eo));
        chk({tag, ":dbz"}, 32'(dif.dbz), 32'(ed));
        @(posedge clk);
        #1;
        chk({tag, ":pulse"}, 32'(dif.done), 32'd0);
        chk({tag, ":hold"},  32'(dif.val),  32'(ev));
    endtask

    initial begin
        int ndone;
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:busy", 32'(dif.busy), 32'd0);
        chk("rst:done", 32'(dif.done), 32'd0);
        chk("rst:val",  32'(dif.val),  32'd0);
        chk("rst:ovf",  32'(dif.ovf),  32'd0);
        chk("rst:dbz",  32'(dif.dbz),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("t1",     25'h0300000, 25'h0180000, 25'h0200000, 1'b0, 1'b0, 47, 0);
        run_div("t2",     25'h0100000, 25'h1D00000, 25'h1FAAAAB, 1'b0, 1'b0, 47, 0);
        run_div("tie0",   25'h0000001, 25'h0200000, 25'h0000000, 1'b0, 1'b0, 47, 0);
        run_div("tie1",   25'h0000003, 25'h0200000, 25'h0000002, 1'b0, 1'b0, 47, 0);
        run_div("ovf1",   25'h0F00000, 25'h0040000, 25'h0FFFFFF, 1'b1, 1'b0, 47, 0);
        run_div("ovf2",   25'h1000000, 25'h1F00000, 25'h0FFFFFF, 1'b1, 1'b0, 47, 0);
        run_div("dbzneg", 25'h1E00000, 25'h0000000, 25'h1000000, 1'b0, 1'b1, 1,  0);
        run_div("dbz0",   25'h0000000, 25'h0000000, 25'h0FFFFFF, 1'b0, 1'b1, 1,  0);
        run_div("ignore", 25'h0300000, 25'h0180000, 25'h0200000, 1'b0, 1'b0, 47, 5);
        run_div("negmin", 25'h1000000, 25'h0100000, 25'h1000000, 1'b0, 1'b0, 47, 0);

        // Reset in the middle of a division.
        @(negedge clk);
        dif.a     = 25'h0300000;
        dif.b     = 25'h0180000;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid:busy", 32'(dif.busy), 32'd0);
        chk("mid:done", 32'(dif.done), 32'd0);
        chk("mid:val",  32'(dif.val),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (dif.done) ndone++;
        end
        chk("mid:nodone", 32'(ndone), 32'd0);

        run_div("after", 25'h1E00000, 25'h0200000, 25'h1F00000, 1'b0, 1'b0, 47, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
